spi_cs_arbiter: RTL and testbench

Shares one SPI host among `NumReq` requesters (e.g. R-Pi SPI0 CE0/CE1, Arduino shield, mikroBUS Click) and drives their chip selects directly, replacing software chip-select control via GPIO outputs. It sits between the requesters' control logic and the SPI host data mux in the system top. It applies round-robin arbitration and enforces programmable chip-select setup, hold and inter-transaction gap times.

---
 rtl/spi_cs_arb_pkg.sv | 33 +++
 rtl/spi_cs_arb_rr_pick.sv | 46 ++++
 rtl/spi_cs_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_cs_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cs_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_cs_arb_pkg
//
// Shared definitions for the SPI chip-select arbiter:
//   - spi_cs_arb_state_e   : arbiter FSM state encoding (3 bits)
//   - SpiCsArbMaxReq       : largest supported number of requesters
//   - spi_cs_arb_cnt_width : width of the setup/hold/gap cycle counter
// -----------------------------------------------------------------------------
package spi_cs_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_GAP    = 3'd5
  } spi_cs_arb_state_e;

  localparam int SpiCsArbMaxReq = 8;

  // The one counter is reused for setup, hold and gap, so it must hold the
  // largest of the three cycle counts.
  function automatic int spi_cs_arb_cnt_width(int setup_cycles, int hold_cycles,
                                              int gap_cycles);
    int max_cycles;
    max_cycles = setup_cycles;
    if (hold_cycles > max_cycles) max_cycles = hold_cycles;
    if (gap_cycles > max_cycles)  max_cycles = gap_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/spi_cs_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// spi_cs_arb_rr_pick
//
// Combinational round-robin picker. Scans the request vector starting at the
// pointer index and wrapping around; the first set bit wins.
//
// Ports:
//   req_i   [NumReq]        request vector
//   ptr_i   [clog2(NumReq)] highest-priority index for this pick
//   found_o                 at least one request is set
//   idx_o   [clog2(NumReq)] winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module spi_cs_arb_rr_pick
  import spi_cs_arb_pkg::*;
#(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic                      found_o,
  output logic [$clog2(NumReq)-1:0] idx_o
);

  localparam int IdxW = $clog2(NumReq);

  always_comb begin
    int               cand;
    logic [IdxW-1:0]  cand_idx;
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdxW'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/spi_cs_arbiter.sv
// -----------------------------------------------------------------------------
// spi_cs_arbiter
//
// Shares one SPI host among NumReq requesters and drives their active-low chip
// selects. Round-robin arbitration; programmable CS setup, hold and minimum
// CS-high gap. One transaction:
//   IDLE -> SETUP (CS low) -> ACTIVE (grant) -> DRAIN (wait SPI idle)
//        -> HOLD (CS still low) -> GAP (all CS high) -> IDLE
// A request dropped during SETUP skips the grant and goes straight to HOLD.
// No preemption: requests are only evaluated in IDLE.
//
// Optional feature (macro SPI_CS_ARB_TIMEOUT_EN):
//   A grant watchdog counts ACTIVE+DRAIN cycles; after TimeoutCycles it sets a
//   sticky timeout_o bit for the owner, drops the grant and forces HOLD
//   regardless of spi_busy_i. Without the macro, timeout_o is tied to 0 and
//   timeout_clr_i is ignored.
//
// Ports:
//   clk_sys_i          system clock
//   rst_sys_ni         asynchronous active-low reset
//   req_i     [N]      per-requester request, held for the whole transaction
//   gnt_o     [N]      one-hot grant (registered)
//   cs_no     [N]      active-low chip selects (registered)
//   sel_o     [log2 N] current owner index for the SPI data mux (registered)
//   busy_o             high in every state except IDLE (registered)
//   spi_busy_i         SPI host still shifting
//   timeout_o [N]      sticky watchdog flags (registered)
//   timeout_clr_i [N]  clears matching timeout_o bit; a same-cycle set wins
// -----------------------------------------------------------------------------
module spi_cs_arbiter
  import spi_cs_arb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int CsSetupCycles = 2,
  parameter int CsHoldCycles  = 2,
  parameter int CsGapCycles   = 1,
  parameter int TimeoutCycles = 65535
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_sys_ni,
  input  logic [NumReq-1:0]         req_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [NumReq-1:0]         cs_no,
  output logic [$clog2(NumReq)-1:0] sel_o,
  output logic                      busy_o,
  input  logic                      spi_busy_i,
  output logic [NumReq-1:0]         timeout_o,
  input  logic [NumReq-1:0]         timeout_clr_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = spi_cs_arb_cnt_width(CsSetupCycles, CsHoldCycles, CsGapCycles);

  // A counting state ends on the edge where the counter holds cycles-1; the
  // counter was cleared on the entry edge, so the state lasts exactly
  // 'cycles' clocks.
  localparam logic [CntW-1:0] SetupLast = CntW'(CsSetupCycles - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CsHoldCycles - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CsGapCycles - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);

  spi_cs_arb_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [NumReq-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic [NumReq-1:0] owner_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;

  logic              to_hit;
  logic              to_fire;

  // ---------------------------------------------------------------------------
  // Round-robin pick among the current requests
  // ---------------------------------------------------------------------------
  spi_cs_arb_rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Saturating increment: the counter never wraps, even if a state lingers.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // The watchdog can only fire while the owner holds (or is draining) the bus.
  assign to_fire = to_hit && ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_SETUP;
          sel_d   = pick_idx;
          // Pointer moves past the winner as soon as it is chosen, so a
          // requester that aborts or times out still yields its turn.
          ptr_d   = (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
        end
      end

      ST_SETUP: begin
        if (!req_i[sel_q]) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == SetupLast) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_ACTIVE: begin
        if (to_fire) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (!req_i[sel_q]) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // A watchdog expiry stops waiting for the SPI host.
        if (to_fire || !spi_busy_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_GAP: begin
        if (cnt_q == GapLast) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every output comes from a register
  // and changes on the same edge as the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d = NumReq'(1) << sel_d;
    gnt_d   = '0;
    cs_n_d  = '1;
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_ACTIVE) gnt_d = owner_d;
    if ((state_d == ST_SETUP) || (state_d == ST_ACTIVE) ||
        (state_d == ST_DRAIN) || (state_d == ST_HOLD)) begin
      cs_n_d = ~owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign cs_no  = cs_n_q;
  assign sel_o  = sel_q;
  assign busy_o = busy_q;

  // ---------------------------------------------------------------------------
  // Grant watchdog
  // ---------------------------------------------------------------------------
`ifdef SPI_CS_ARB_TIMEOUT_EN
  // The counter holds the number of ACTIVE/DRAIN cycles already completed, so
  // the watchdog fires on the edge that would complete cycle TimeoutCycles.
  localparam logic [31:0] ToLast = 32'(TimeoutCycles - 1);

  logic [31:0]       to_cnt_q, to_cnt_d;
  logic [NumReq-1:0] timeout_q, timeout_d;

  assign to_hit = (to_cnt_q >= ToLast);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q == ST_SETUP) && (state_d == ST_ACTIVE)) begin
      to_cnt_d = '0;
    end else if (((state_q == ST_ACTIVE) || (state_q == ST_DRAIN)) && !(&to_cnt_q)) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end

    // Set is applied after clear so a simultaneous set wins.
    timeout_d = timeout_q & ~timeout_clr_i;
    if (to_fire) timeout_d = timeout_d | (NumReq'(1) << sel_q);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      to_cnt_q  <= '0;
      timeout_q <= '0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign timeout_o          = '0;
  assign unused_timeout_cfg = ^{timeout_clr_i, 32'(TimeoutCycles)};
`endif

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_cs_arbiter
//
// Directed bench for spi_cs_arbiter (NumReq=4, setup 2, hold 2, gap 1,
// watchdog 16). Stimulus pushes hand-computed expectations into two queues:
// per-cycle output snapshots and the expected grant order. A monitor on the
// falling clock edge pops and compares them, and also checks the one-hot /
// CS-gap invariants every cycle. The watchdog scenario runs only when
// SPI_CS_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_spi_cs_arbiter;

  localparam int K_CS   = 0;
  localparam int K_GNT  = 1;
  localparam int K_SEL  = 2;
  localparam int K_BUSY = 3;
  localparam int K_TO   = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0;
  logic [3:0] clr = 4'h0;
  logic       spi_busy = 1'b0;
  logic [3:0] gnt, cs_n, to;
  logic [1:0] sel;
  logic       busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   gnt_exp_q[$];
  logic [3:0] prev_cs  = 4'hF;
  logic [3:0] prev_gnt = 4'h0;

  always #5 clk = ~clk;

  spi_cs_arbiter #(
    .NumReq        (4),
    .CsSetupCycles (2),
    .CsHoldCycles  (2),
    .CsGapCycles   (1),
    .TimeoutCycles (16)
  ) dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_n),
    .req_i         (req),
    .gnt_o         (gnt),
    .cs_no         (cs_n),
    .sel_o         (sel),
    .busy_o        (busy),
    .spi_busy_i    (spi_busy),
    .timeout_o     (to),
    .timeout_clr_i (clr)
  );

  // Edge counter: after posedge number e, cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [31:0] probe(int kind);
    case (kind)
      K_CS:    return 32'(cs_n);
      K_GNT:   return 32'(gnt);
      K_SEL:   return 32'(sel);
      K_BUSY:  return 32'(busy);
      default: return 32'(to);
    endcase
  endfunction

  // Insert keeping the queue ordered by cycle.
  task automatic expect_at(int e_cyc, int kind, logic [7:0] val, string name);
    exp_t e;
    int   pos;
    e.cyc  = e_cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    pos = exp_q.size();
    while (pos > 0 && exp_q[pos-1].cyc > e_cyc) pos--;
    exp_q.insert(pos, e);
  endtask

  // Returns 2 time units after posedge number e (inputs set here are sampled
  // at edge e+1).
  task automatic goto_edge(int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      check("inv_one_cs_low", 32'($countones(~cs_n) <= 1), 32'd1);
      check("inv_one_gnt",    32'($countones(gnt) <= 1), 32'd1);
      check("inv_gnt_needs_cs", 32'(gnt & cs_n), 32'd0);
      if (cs_n != 4'hF && cs_n != prev_cs) check("cs_gap_before_assert", 32'(prev_cs), 32'hF);
      if (gnt != 4'h0 && prev_gnt == 4'h0) begin
        if (gnt_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL gnt_unexpected (cycle %0d): got %0h, expected no grant", cyc, gnt);
        end else begin
          check("gnt_order", 32'(gnt), 32'(1) << gnt_exp_q.pop_front());
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: expected at cycle %0d, got no sample (now %0d)", e.name, e.cyc, cyc);
        end else begin
          check(e.name, probe(e.kind), 32'(e.val));
        end
      end
    end
    prev_cs  <= cs_n;
    prev_gnt <= gnt;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         b;
    int         g;
    int         idx;
    logic [3:0] oh;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #2;
    check("rst_cs",   32'(cs_n), 32'hF);
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_sel",  32'(sel),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_to",   32'(to),   32'h0);
    rst_n = 1'b1;
    expect_at(cyc + 1, K_BUSY, 8'h0, "idle_busy");
    expect_at(cyc + 1, K_CS,   8'hF, "idle_cs");
    goto_edge(cyc + 2);

    // Single request from requester 1, SPI idle when it releases.
    b = cyc + 1;
    req = 4'b0010;
    gnt_exp_q.push_back(1);
    expect_at(b + 0,  K_CS,   8'hD, "single_cs_assert");
    expect_at(b + 0,  K_SEL,  8'h1, "single_sel");
    expect_at(b + 0,  K_BUSY, 8'h1, "single_busy");
    expect_at(b + 1,  K_GNT,  8'h0, "single_no_early_gnt");
    expect_at(b + 2,  K_GNT,  8'h2, "single_gnt");
    expect_at(b + 9,  K_GNT,  8'h2, "single_gnt_held");
    expect_at(b + 10, K_GNT,  8'h0, "single_gnt_drop");
    expect_at(b + 10, K_CS,   8'hD, "single_cs_drain");
    expect_at(b + 12, K_CS,   8'hD, "single_cs_hold");
    expect_at(b + 13, K_CS,   8'hF, "single_cs_release");
    expect_at(b + 13, K_BUSY, 8'h1, "single_busy_gap");
    expect_at(b + 14, K_BUSY, 8'h0, "single_idle");
    goto_edge(b + 9);
    req = 4'b0000;
    goto_edge(b + 16);

    // Drain: requester 2 releases while the SPI host shifts 7 more cycles.
    b = cyc + 1;
    req = 4'b0100;
    spi_busy = 1'b1;
    gnt_exp_q.push_back(2);
    expect_at(b + 0,  K_CS,   8'hB, "drain_cs_assert");
    expect_at(b + 2,  K_GNT,  8'h4, "drain_gnt");
    expect_at(b + 6,  K_GNT,  8'h0, "drain_gnt_drop");
    expect_at(b + 6,  K_CS,   8'hB, "drain_cs_wait");
    expect_at(b + 13, K_CS,   8'hB, "drain_cs_busy_fell");
    expect_at(b + 14, K_CS,   8'hB, "drain_cs_hold");
    expect_at(b + 15, K_CS,   8'hF, "drain_cs_release");
    expect_at(b + 16, K_BUSY, 8'h0, "drain_idle");
    goto_edge(b + 5);
    req = 4'b0000;
    goto_edge(b + 12);
    spi_busy = 1'b0;
    goto_edge(b + 18);

    // Abort in SETUP: requester 3 pulses for a single cycle.
    b = cyc + 1;
    req = 4'b1000;
    expect_at(b + 0, K_CS,   8'h7, "abort_cs_assert");
    expect_at(b + 0, K_GNT,  8'h0, "abort_no_gnt0");
    expect_at(b + 1, K_GNT,  8'h0, "abort_no_gnt1");
    expect_at(b + 2, K_CS,   8'h7, "abort_cs_hold");
    expect_at(b + 2, K_GNT,  8'h0, "abort_no_gnt2");
    expect_at(b + 3, K_CS,   8'hF, "abort_cs_release");
    expect_at(b + 3, K_BUSY, 8'h1, "abort_busy_gap");
    expect_at(b + 4, K_BUSY, 8'h0, "abort_idle");
    goto_edge(b);
    req = 4'b0000;
    goto_edge(b + 6);

    // Asynchronous reset while requester 1 holds the grant.
    b = cyc + 1;
    req = 4'b0010;
    gnt_exp_q.push_back(1);
    expect_at(b + 2, K_GNT, 8'h2, "arst_gnt_before");
    expect_at(b + 2, K_SEL, 8'h1, "arst_sel_before");
    goto_edge(b + 3);
    rst_n = 1'b0;
    #1;
    check("arst_cs",   32'(cs_n), 32'hF);
    check("arst_gnt",  32'(gnt),  32'h0);
    check("arst_sel",  32'(sel),  32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    goto_edge(b + 5);

    // Round robin after reset: all four request, each releases 4 cycles after
    // its grant and re-requests; grants every 11 cycles in order 0,1,2,3,0.
    b = cyc + 1;
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      g   = b + 2 + 11 * n;
      idx = n % 4;
      oh  = 4'(1 << idx);
      gnt_exp_q.push_back(idx);
      expect_at(g,     K_GNT, {4'h0, oh},   "rr_gnt");
      expect_at(g,     K_SEL, 8'(idx),      "rr_sel");
      expect_at(g + 4, K_GNT, 8'h0,         "rr_gnt_drop");
      expect_at(g + 7, K_CS,  8'hF,         "rr_gap");
      if (n < 4) begin
        oh = 4'(1 << ((idx + 1) % 4));
        expect_at(g + 9, K_CS, {4'h0, ~oh}, "rr_next_cs");
      end
    end
    for (int n = 0; n < 5; n++) begin
      g   = b + 2 + 11 * n;
      idx = n % 4;
      goto_edge(g + 3);
      req[idx] = 1'b0;
      goto_edge(g + 5);
      if (n < 4) req[idx] = 1'b1;
      else       req = 4'h0;
    end
    goto_edge(b + 2 + 44 + 10);

`ifdef SPI_CS_ARB_TIMEOUT_EN
    // Watchdog: requester 2 never releases; requester 3 waits behind it.
    b = cyc + 1;
    req = 4'b0100;
    gnt_exp_q.push_back(2);
    gnt_exp_q.push_back(3);
    expect_at(b + 2,  K_GNT, 8'h4, "to_gnt");
    expect_at(b + 17, K_GNT, 8'h4, "to_gnt_last_cycle");
    expect_at(b + 17, K_TO,  8'h0, "to_not_yet");
    expect_at(b + 18, K_GNT, 8'h0, "to_gnt_drop");
    expect_at(b + 18, K_TO,  8'h4, "to_flag_set");
    expect_at(b + 18, K_CS,  8'hB, "to_cs_hold");
    expect_at(b + 20, K_CS,  8'hF, "to_cs_release");
    expect_at(b + 22, K_CS,  8'h7, "to_next_cs");
    expect_at(b + 24, K_GNT, 8'h8, "to_next_gnt");
    expect_at(b + 24, K_SEL, 8'h3, "to_next_sel");
    expect_at(b + 24, K_TO,  8'h4, "to_flag_sticky");
    expect_at(b + 27, K_TO,  8'h0, "to_flag_cleared");
    goto_edge(b + 5);
    req = 4'b1100;
    goto_edge(b + 25);
    req = 4'b0000;
    goto_edge(b + 26);
    clr = 4'b0100;
    goto_edge(b + 27);
    clr = 4'b0000;
    goto_edge(b + 32);
`else
    // Without the watchdog, timeout_o stays 0 and the clear input is inert.
    b = cyc + 1;
    clr = 4'hF;
    expect_at(b,     K_TO, 8'h0, "to_disabled");
    expect_at(b + 1, K_TO, 8'h0, "to_disabled_after");
    goto_edge(b);
    clr = 4'h0;
    goto_edge(b + 3);
`endif

    goto_edge(cyc + 2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("grant_queue_drained", 32'(gnt_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
